edge_window_scheduler: RTL
==========================

Name: edge_window_scheduler

Overview:
Front-end controller for the 3x3 edge-detection/blur kernel. Accepts a raster pixel stream, builds the a1..a9 neighbourhood using two line buffers, and presents one window per interior pixel to the kernel over a valid/ready handshake. Latches kernel configuration (select, threshold) once per frame, so it stays stable for the whole frame. Sits between the pixel source (BRAM/UART loader) and the kernel.

Parameters:
IMG_WIDTH, 850, pixels per row (>=3)
IMG_HEIGHT, 850, rows per frame (>=3)
PIX_W, 8, pixel width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin frame; ignored unless IDLE
cfg_select  in  2  kernel select, sampled on accepted start
cfg_threshold  in  8  kernel threshold, sampled on accepted start
pix_in  in  PIX_W  raster pixel, row-major
pix_in_valid  in  1  pix_in valid
pix_in_ready  out  1  pixel accepted when valid&&ready
a1..a9  out  PIX_W each  window: a1 a2 a3 / a4 a5 a6 / a7 a8 a9, a5 = centre
win_valid  out  1  window valid
win_ready  in  1  kernel accepts window
select  out  2  latched kernel select
threshold  out  8  latched kernel threshold
busy  out  1  high when not IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; row/col counters 0; a1..a9=0; win_valid=0; pix_in_ready=0; busy=0; frame_done=0; select=2'b00; threshold=8'd100. Line buffer contents don't care. Reset mid-frame aborts the frame silently, with no frame_done.
- States: IDLE -> (start) RUN -> (last pixel (H-1,W-1) accepted) DRAIN -> (final window handshaken) DONE -> IDLE after 1 cycle. frame_done=1 only in DONE.
- Accepting start in IDLE latches cfg_select/cfg_threshold into select/threshold and clears row/col. start outside IDLE has no effect.
- pix_in_ready = (state==RUN) && !(win_valid && !win_ready).
- On each accepted pixel at (r,c): write it into line buffer 0 at column c; move the old lb0[c] into lb1[c]; shift the 3x3 column registers. col wraps at W-1 to 0 and row increments. Counter widths: $clog2 of the dimension.
- Window emission: accepting pixel (r,c) with r>=2 and c>=2 registers a window for centre (r-1,c-1): a1=(r-2,c-2), a5=(r-1,c-1), a9=(r,c). win_valid rises the next cycle, so latency is 1 clk.
- win_valid and a1..a9 hold stable until win_ready=1. win_valid clears after the handshake unless a new window is loaded in the same cycle, which keeps win_valid high with the new data.
- Windows per frame: exactly (W-2)*(H-2). Border pixels (row 0, row H-1, col 0, col W-1 as centre) produce no window.
- Row wrap: window columns don't span rows. A window is emitted only when c>=2 in the current row.
- Input bubbles (pix_in_valid=0) stall the counters without side effects.

Optional Feature:
FRAME_COUNTER_EN: when defined, adds output frame_count[15:0]. It resets to 0, increments in DONE, and wraps at 0xFFFF->0. When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clk -> win_valid=0, pix_in_ready=0, busy=0, select=0, threshold=100.
- Full frame, W=5 H=4, pixel=r*16+c, continuous valid, win_ready=1 -> 6 windows. First window a1..a9 = 00,01,02,10,11,12,20,21,22. Last window a5=23, a9=34. frame_done pulses once, 1 clk after last handshake.
- Backpressure: win_ready=0 for 3 clk after first window -> a1..a9 and win_valid held, pix_in_ready=0, all 6 windows still correct and in order.
- Bubbles: pix_in_valid alternating 1/0 -> same 6 windows, same values as the continuous case.
- Config: start with cfg_select=2, cfg_threshold=50 -> select=2, threshold=50. A start with cfg_select=1 mid-frame -> select stays 2, frame unaffected.
- Reset mid-frame after 7 pixels, then a new start with a full frame -> no frame_done for the aborted frame, and the new frame matches the full-frame results.

Source files
------------

// File: rtl/edge_window_scheduler_if.sv
// Bus between the pixel source, the window scheduler and the 3x3 kernel.
// The master modport is the scheduler's view; the slave modport is the source/kernel side.
interface edge_window_scheduler_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic [PIX_W-1:0] a1;
    logic [PIX_W-1:0] a2;
    logic [PIX_W-1:0] a3;
    logic [PIX_W-1:0] a4;
    logic [PIX_W-1:0] a5;
    logic [PIX_W-1:0] a6;
    logic [PIX_W-1:0] a7;
    logic [PIX_W-1:0] a8;
    logic [PIX_W-1:0] a9;
    logic             win_valid;
    logic             win_ready;

    modport master (
        input  pix_in, pix_in_valid, win_ready,
        output pix_in_ready, a1, a2, a3, a4, a5, a6, a7, a8, a9, win_valid
    );

    modport slave (
        output pix_in, pix_in_valid, win_ready,
        input  pix_in_ready, a1, a2, a3, a4, a5, a6, a7, a8, a9, win_valid
    );
endinterface

// File: rtl/edge_window_scheduler.sv
// Raster-to-3x3-window front end for the edge/blur kernel, with per-frame config latching.
// Optional FRAME_COUNTER_EN adds a 16-bit completed-frame counter output.
module edge_window_scheduler #(
    parameter int IMG_WIDTH  = 850,
    parameter int IMG_HEIGHT = 850,
    parameter int PIX_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [1:0]              cfg_select_i,
    input  logic [7:0]              cfg_threshold_i,
    edge_window_scheduler_if.master win_if,
    output logic [1:0]              select_o,
    output logic [7:0]              threshold_o,
    output logic                    busy_o,
    output logic                    frame_done_o
`ifdef FRAME_COUNTER_EN
    ,
    output logic [15:0]             frame_count_o
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q;
    logic [RW-1:0]    row_q;
    logic [RW-1:0]    row_d;
    logic [CW-1:0]    col_q;
    logic [CW-1:0]    col_d;
    logic [PIX_W-1:0] lineBuf0_q [IMG_WIDTH];
    logic [PIX_W-1:0] lineBuf1_q [IMG_WIDTH];
    logic [PIX_W-1:0] top_q [2];
    logic [PIX_W-1:0] mid_q [2];
    logic [PIX_W-1:0] bot_q [2];
    logic [PIX_W-1:0] win_q [9];
    logic             winValid_q;
    logic [1:0]       select_q;
    logic [7:0]       threshold_q;
    logic             busy_q;
    logic             frameDone_q;
`ifdef FRAME_COUNTER_EN
    logic [15:0]      frameCount_q;
`endif

    logic             pixReady;
    logic             pixAccept;
    logic             winTake;
    logic             atLastCol;
    logic             lastPix;
    logic             winLoad;
    logic [PIX_W-1:0] above1;
    logic [PIX_W-1:0] above2;

    // above1/above2 are the pixels one and two rows up in the current column.
    always_comb begin
        pixReady  = (state_q == RUN) && !(winValid_q && !win_if.win_ready);
        pixAccept = pixReady && win_if.pix_in_valid;
        winTake   = winValid_q && win_if.win_ready;
        atLastCol = (col_q == COL_LAST);
        lastPix   = atLastCol && (row_q == ROW_LAST);
        winLoad   = pixAccept && (row_q >= RW'(2)) && (col_q >= CW'(2));
        col_d     = atLastCol ? '0 : col_q + 1'b1;
        row_d     = atLastCol ? row_q + 1'b1 : row_q;
        above1    = lineBuf0_q[col_q];
        above2    = lineBuf1_q[col_q];
    end

    always_ff @(posedge clk) begin
        if (pixAccept) begin
            lineBuf0_q[col_q] <= win_if.pix_in;
            lineBuf1_q[col_q] <= above1;
            top_q[0]          <= top_q[1];
            top_q[1]          <= above2;
            mid_q[0]          <= mid_q[1];
            mid_q[1]          <= above1;
            bot_q[0]          <= bot_q[1];
            bot_q[1]          <= win_io_pix();
        end
    end

    function automatic logic [PIX_W-1:0] win_io_pix();
        return win_if.pix_in;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            winValid_q  <= 1'b0;
            select_q    <= 2'b00;
            threshold_q <= 8'd100;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
`ifdef FRAME_COUNTER_EN
            frameCount_q <= '0;
`endif
        end else begin
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        select_q    <= cfg_select_i;
                        threshold_q <= cfg_threshold_i;
                        row_q       <= '0;
                        col_q       <= '0;
                    end
                end
                RUN: begin
                    if (pixAccept) begin
                        row_q <= row_d;
                        col_q <= col_d;
                        if (lastPix) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (winTake) begin
                        state_q     <= DONE;
                        frameDone_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifdef FRAME_COUNTER_EN
                    frameCount_q <= frameCount_q + 16'd1;
`endif
                end
                default: state_q <= IDLE;
            endcase

            // A load can coincide with the kernel taking the previous window; the new one wins.
            if (winLoad) begin
                win_q[0]   <= top_q[0];
                win_q[1]   <= top_q[1];
                win_q[2]   <= above2;
                win_q[3]   <= mid_q[0];
                win_q[4]   <= mid_q[1];
                win_q[5]   <= above1;
                win_q[6]   <= bot_q[0];
                win_q[7]   <= bot_q[1];
                win_q[8]   <= win_if.pix_in;
                winValid_q <= 1'b1;
            end else if (winTake) begin
                winValid_q <= 1'b0;
            end
        end
    end

    assign win_if.pix_in_ready = pixReady;
    assign win_if.win_valid    = winValid_q;
    assign win_if.a1           = win_q[0];
    assign win_if.a2           = win_q[1];
    assign win_if.a3           = win_q[2];
    assign win_if.a4           = win_q[3];
    assign win_if.a5           = win_q[4];
    assign win_if.a6           = win_q[5];
    assign win_if.a7           = win_q[6];
    assign win_if.a8           = win_q[7];
    assign win_if.a9           = win_q[8];
    assign select_o            = select_q;
    assign threshold_o         = threshold_q;
    assign busy_o              = busy_q;
    assign frame_done_o        = frameDone_q;
`ifdef FRAME_COUNTER_EN
    assign frame_count_o       = frameCount_q;
`endif

endmodule
